// File: rtl/dram_device_model.sv
// Single-bank DRAM behavioural device: ACT/PRE/RD/WR with tRCD/tRP spacing, read data CAS_LAT edges after RD.
// One-cycle DRAM_valid per accepted RD; no backpressure, protocol violations latch the sticky dram_err flag.
module dram_device_model #(
  parameter int ROW_BITS = 11,
  parameter int COL_BITS = 10,
  parameter int CAS_LAT  = 5,
  parameter int TRCD     = 5,
  parameter int TRP      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DRAM_CSn,
  input  logic        DRAM_RASn,
  input  logic        DRAM_CASn,
  input  logic [3:0]  DRAM_WEn,
  input  logic [10:0] DRAM_A,
  input  logic [31:0] DRAM_D,
  output logic [31:0] DRAM_Q,
  output logic        DRAM_valid,
  output logic        dram_err
);

  localparam int AW    = ROW_BITS + COL_BITS;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TRCD_LD = CNT_W'((TRCD    > 0) ? TRCD    - 1 : 0);
  localparam logic [CNT_W-1:0] TRP_LD  = CNT_W'((TRP     > 0) ? TRP     - 1 : 0);
  localparam logic [CNT_W-1:0] LAT_LD  = CNT_W'((CAS_LAT > 0) ? CAS_LAT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  state_e               state_q;
  logic [ROW_BITS-1:0]  row_q;
  logic [AW-1:0]        raddr_q;
  logic [CNT_W-1:0]     trcd_q;
  logic [CNT_W-1:0]     trp_q;
  logic [CNT_W-1:0]     lat_q;
  logic [31:0]          q_q;
  logic                 valid_q;
  logic                 err_q;

  logic [31:0] mem [0:(1<<AW)-1];

  logic cmd_act, cmd_pre, cmd_rd, cmd_wr, cmd_ill, cmd_any;
  logic wr_en;
  logic [AW-1:0] col_addr_d;

  always_comb begin
    cmd_act = 1'b0;
    cmd_pre = 1'b0;
    cmd_rd  = 1'b0;
    cmd_wr  = 1'b0;
    cmd_ill = 1'b0;
    if (!DRAM_CSn && !(DRAM_RASn && DRAM_CASn)) begin
      if (!DRAM_RASn && DRAM_CASn) begin
        if (DRAM_WEn == 4'hf)      cmd_act = 1'b1;
        else if (DRAM_WEn == 4'h0) cmd_pre = 1'b1;
        else                       cmd_ill = 1'b1;
      end else if (DRAM_RASn && !DRAM_CASn) begin
        if (DRAM_WEn == 4'hf) cmd_rd = 1'b1;
        else                  cmd_wr = 1'b1;
      end else begin
        cmd_ill = 1'b1;
      end
    end
  end

  assign cmd_any    = cmd_act | cmd_pre | cmd_rd | cmd_wr | cmd_ill;
  assign col_addr_d = {row_q, DRAM_A[COL_BITS-1:0]};
  assign wr_en      = cmd_wr && (state_q == ACTIVE) && (trcd_q == '0);

  // Storage has no reset so written data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (!DRAM_WEn[b]) mem[col_addr_d][8*b +: 8] <= DRAM_D[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      raddr_q <= '0;
      trcd_q  <= '0;
      trp_q   <= '0;
      lat_q   <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (trcd_q != '0) trcd_q <= trcd_q - 1'b1;
      if (trp_q  != '0) trp_q  <= trp_q  - 1'b1;
      if (cmd_ill) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (cmd_act) begin
            if (trp_q == '0) begin
              state_q <= ACTIVE;
              row_q   <= DRAM_A[ROW_BITS-1:0];
              trcd_q  <= TRCD_LD;
            end else begin
              err_q <= 1'b1;
            end
          end else if (cmd_rd || cmd_wr || cmd_pre) begin
            err_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cmd_rd || cmd_wr) begin
            if (trcd_q != '0) begin
              err_q <= 1'b1;
            end else if (cmd_rd) begin
              state_q <= RDWAIT;
              lat_q   <= LAT_LD;
              raddr_q <= col_addr_d;
            end
          end else if (cmd_pre) begin
            state_q <= IDLE;
            trp_q   <= TRP_LD;
          end else if (cmd_act) begin
            err_q <= 1'b1;
          end
        end
        RDWAIT: begin
          if (cmd_any) err_q <= 1'b1;
          if (lat_q == '0) begin
            q_q     <= mem[raddr_q];
            valid_q <= 1'b1;
            state_q <= ACTIVE;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DRAM_Q     = q_q;
  assign DRAM_valid = valid_q;
  assign dram_err   = err_q;

endmodule

// File: tb/tb_dram_device_model.sv
// Bench for dram_device_model: timestamp-based reference model (edge numbers, not counters)
// with directed scenarios plus a randomized legal command stream.
module tb_dram_device_model;

  localparam int CAS_LAT = 5;
  localparam int TRCD    = 5;
  localparam int TRP     = 5;

  typedef enum int {K_NOP, K_ACT, K_PRE, K_RD, K_WR, K_ILL} kind_t;
  typedef struct {
    kind_t       k;
    int          a;
    logic [31:0] d;
    logic [3:0]  wen;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D;
  logic [31:0] DRAM_Q;
  logic        DRAM_valid;
  logic        dram_err;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  dram_device_model #(
    .ROW_BITS(11), .COL_BITS(10), .CAS_LAT(CAS_LAT), .TRCD(TRCD), .TRP(TRP)
  ) dut (
    .clk(clk), .rst(rst),
    .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
    .DRAM_WEn(DRAM_WEn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D),
    .DRAM_Q(DRAM_Q), .DRAM_valid(DRAM_valid), .dram_err(dram_err)
  );

  // Reference model state: edge timestamps instead of countdown timers.
  int          edge_n = 0;
  bit          m_open;
  int          m_row;
  int          m_act_edge;
  int          m_pre_edge;
  bit          m_rd_pend;
  int          m_rd_due;
  int          m_rd_addr;
  bit          m_err;
  bit          m_valid;
  logic [31:0] m_q;
  logic [31:0] m_mem [int];

  function automatic cmd_t mk(kind_t k, int a, logic [31:0] d, logic [3:0] w);
    cmd_t c;
    c.k = k; c.a = a; c.d = d; c.wen = w;
    return c;
  endfunction

  task automatic model_reset();
    m_open = 0; m_row = 0; m_act_edge = -1000; m_pre_edge = -1000;
    m_rd_pend = 0; m_rd_due = 0; m_rd_addr = 0;
    m_err = 0; m_valid = 0; m_q = '0;
  endtask

  task automatic model_step(input cmd_t c);
    int          addr;
    logic [31:0] w;
    edge_n++;
    m_valid = 0;
    if (m_rd_pend) begin
      if (c.k != K_NOP) m_err = 1;
      if (edge_n == m_rd_due) begin
        m_q = m_mem.exists(m_rd_addr) ? m_mem[m_rd_addr] : 32'h0;
        m_valid = 1;
        m_rd_pend = 0;
      end
    end else begin
      case (c.k)
        K_ILL: m_err = 1;
        K_ACT: begin
          if (!m_open && (edge_n - m_pre_edge) >= TRP) begin
            m_open = 1; m_row = c.a % 2048; m_act_edge = edge_n;
          end else m_err = 1;
        end
        K_PRE: begin
          if (m_open) begin m_open = 0; m_pre_edge = edge_n; end
          else m_err = 1;
        end
        K_RD, K_WR: begin
          if (m_open && (edge_n - m_act_edge) >= TRCD) begin
            addr = m_row * 1024 + (c.a % 1024);
            if (c.k == K_RD) begin
              m_rd_pend = 1; m_rd_due = edge_n + CAS_LAT; m_rd_addr = addr;
            end else begin
              w = m_mem.exists(addr) ? m_mem[addr] : 32'h0;
              for (int b = 0; b < 4; b++) if (!c.wen[b]) w[8*b +: 8] = c.d[8*b +: 8];
              m_mem[addr] = w;
            end
          end else m_err = 1;
        end
        default: ;
      endcase
    end
  endtask

  // Drive one command, let one edge pass, update the model, settle away from the edge.
  task automatic cyc(input cmd_t c);
    DRAM_CSn = 1'b0; DRAM_A = c.a[10:0]; DRAM_D = $urandom;
    case (c.k)
      K_ACT: begin DRAM_RASn = 0; DRAM_CASn = 1; DRAM_WEn = 4'hf; end
      K_PRE: begin DRAM_RASn = 0; DRAM_CASn = 1; DRAM_WEn = 4'h0; end
      K_RD:  begin DRAM_RASn = 1; DRAM_CASn = 0; DRAM_WEn = 4'hf; end
      K_WR:  begin DRAM_RASn = 1; DRAM_CASn = 0; DRAM_WEn = c.wen; DRAM_D = c.d; end
      K_ILL: begin DRAM_RASn = 0; DRAM_CASn = 0; DRAM_WEn = 4'($urandom); end
      default: begin
        DRAM_CSn = 1; DRAM_RASn = 1'($urandom); DRAM_CASn = 1'($urandom);
        DRAM_WEn = 4'($urandom); DRAM_A = 11'($urandom);
      end
    endcase
    @(posedge clk);
    model_step(c);
    #1;
  endtask

  task automatic do_reset();
    DRAM_CSn = 1; DRAM_RASn = 1; DRAM_CASn = 1; DRAM_WEn = 4'hf;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    cmd_t q[$];
    do_reset();
    tests_run += 3;
    if (DRAM_Q !== 32'h0)    begin fails++; $display("FAIL reset_q got %h exp 0", DRAM_Q); end
    if (DRAM_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", DRAM_valid); end
    if (dram_err !== 1'b0)   begin fails++; $display("FAIL reset_err got %b exp 0", dram_err); end
    repeat (10) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    foreach (q[i]) begin
      cyc(q[i]);
      tests_run += 3;
      if (DRAM_valid !== m_valid) begin fails++; $display("FAIL idle_valid e%0d got %b exp %b", edge_n, DRAM_valid, m_valid); end
      if (DRAM_Q !== m_q)         begin fails++; $display("FAIL idle_q e%0d got %h exp %h", edge_n, DRAM_Q, m_q); end
      if (dram_err !== m_err)     begin fails++; $display("FAIL idle_err e%0d got %b exp %b", edge_n, dram_err, m_err); end
    end
  endtask

  task automatic test_write_read();
    cmd_t q[$];
    int rd_i = -1, lat = -1;
    q.push_back(mk(K_ACT, 3, 0, 4'hf));
    repeat (5) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    q.push_back(mk(K_WR, 7, 32'hA5A5_1234, 4'h0));
    q.push_back(mk(K_RD, 7, 0, 4'hf));
    repeat (7) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    foreach (q[i]) begin
      cyc(q[i]);
      if (q[i].k == K_RD) rd_i = i;
      if (DRAM_valid === 1'b1 && lat < 0 && rd_i >= 0) lat = i - rd_i;
      tests_run += 3;
      if (DRAM_valid !== m_valid) begin fails++; $display("FAIL wr_rd_valid e%0d got %b exp %b", edge_n, DRAM_valid, m_valid); end
      if (DRAM_Q !== m_q)         begin fails++; $display("FAIL wr_rd_q e%0d got %h exp %h", edge_n, DRAM_Q, m_q); end
      if (dram_err !== m_err)     begin fails++; $display("FAIL wr_rd_err e%0d got %b exp %b", edge_n, dram_err, m_err); end
    end
    tests_run += 3;
    if (lat != CAS_LAT)          begin fails++; $display("FAIL rd_latency got %0d exp %0d", lat, CAS_LAT); end
    if (DRAM_Q !== 32'hA5A5_1234) begin fails++; $display("FAIL rd_data got %h exp a5a51234", DRAM_Q); end
    if (dram_err !== 1'b0)        begin fails++; $display("FAIL wr_rd_err_final got %b exp 0", dram_err); end
  endtask

  task automatic test_byte_write();
    cmd_t q[$];
    q.push_back(mk(K_WR, 9, 32'h1122_3344, 4'h0));
    q.push_back(mk(K_WR, 9, 32'hFFFF_FFFF, 4'b1101));
    q.push_back(mk(K_RD, 9, 0, 4'hf));
    repeat (6) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    foreach (q[i]) begin
      cyc(q[i]);
      tests_run += 3;
      if (DRAM_valid !== m_valid) begin fails++; $display("FAIL byte_valid e%0d got %b exp %b", edge_n, DRAM_valid, m_valid); end
      if (DRAM_Q !== m_q)         begin fails++; $display("FAIL byte_q e%0d got %h exp %h", edge_n, DRAM_Q, m_q); end
      if (dram_err !== m_err)     begin fails++; $display("FAIL byte_err e%0d got %b exp %b", edge_n, dram_err, m_err); end
    end
    tests_run++;
    if (DRAM_Q !== 32'h1122_FF44) begin fails++; $display("FAIL byte_merge got %h exp 1122ff44", DRAM_Q); end
  endtask

  task automatic test_violations();
    cmd_t q[$];
    int nval = 0;
    q.push_back(mk(K_PRE, 0, 0, 4'h0));
    repeat (5) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    q.push_back(mk(K_ACT, 5, 0, 4'hf));
    q.push_back(mk(K_NOP, 0, 0, 4'hf));
    q.push_back(mk(K_RD, 0, 0, 4'hf));
    repeat (8) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    q.push_back(mk(K_PRE, 0, 0, 4'h0));
    q.push_back(mk(K_NOP, 0, 0, 4'hf));
    q.push_back(mk(K_ACT, 5, 0, 4'hf));
    repeat (5) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    q.push_back(mk(K_RD, 0, 0, 4'hf));
    repeat (8) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    foreach (q[i]) begin
      cyc(q[i]);
      if (DRAM_valid === 1'b1) nval++;
      tests_run += 3;
      if (DRAM_valid !== m_valid) begin fails++; $display("FAIL viol_valid e%0d got %b exp %b", edge_n, DRAM_valid, m_valid); end
      if (DRAM_Q !== m_q)         begin fails++; $display("FAIL viol_q e%0d got %h exp %h", edge_n, DRAM_Q, m_q); end
      if (dram_err !== m_err)     begin fails++; $display("FAIL viol_err e%0d got %b exp %b", edge_n, dram_err, m_err); end
    end
    tests_run += 2;
    if (nval != 0)         begin fails++; $display("FAIL viol_no_valid got %0d pulses exp 0", nval); end
    if (dram_err !== 1'b1) begin fails++; $display("FAIL viol_sticky_err got %b exp 1", dram_err); end
  endtask

  task automatic test_back_to_back();
    cmd_t q[$];
    int nval = 0, budget = 0;
    do_reset();
    q.push_back(mk(K_ACT, 100, 0, 4'hf));
    repeat (5) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    for (int i = 0; i < 4; i++) q.push_back(mk(K_WR, 40 + i, 32'hC0DE_0000 + i, 4'h0));
    q.push_back(mk(K_RD, 40, 0, 4'hf));
    foreach (q[i]) begin
      cyc(q[i]);
      tests_run += 3;
      if (DRAM_valid !== m_valid) begin fails++; $display("FAIL b2b_pre_valid e%0d got %b exp %b", edge_n, DRAM_valid, m_valid); end
      if (DRAM_Q !== m_q)         begin fails++; $display("FAIL b2b_pre_q e%0d got %h exp %h", edge_n, DRAM_Q, m_q); end
      if (dram_err !== m_err)     begin fails++; $display("FAIL b2b_pre_err e%0d got %b exp %b", edge_n, dram_err, m_err); end
    end
    while (nval < 4 && budget < 60) begin
      budget++;
      if (DRAM_valid === 1'b1) begin
        tests_run++;
        if (DRAM_Q !== 32'hC0DE_0000 + nval) begin
          fails++; $display("FAIL b2b_data%0d got %h exp %h", nval, DRAM_Q, 32'hC0DE_0000 + nval);
        end
        nval++;
      end
      if (nval < 4) begin
        if (DRAM_valid === 1'b1) cyc(mk(K_RD, 40 + nval, 0, 4'hf));
        else                     cyc(mk(K_NOP, 0, 0, 4'hf));
        tests_run += 3;
        if (DRAM_valid !== m_valid) begin fails++; $display("FAIL b2b_valid e%0d got %b exp %b", edge_n, DRAM_valid, m_valid); end
        if (DRAM_Q !== m_q)         begin fails++; $display("FAIL b2b_q e%0d got %h exp %h", edge_n, DRAM_Q, m_q); end
        if (dram_err !== m_err)     begin fails++; $display("FAIL b2b_err e%0d got %b exp %b", edge_n, dram_err, m_err); end
      end
    end
    tests_run++;
    if (nval != 4) begin fails++; $display("FAIL b2b_count got %0d valids exp 4 (budget %0d)", nval, budget); end
    q.delete();
    q.push_back(mk(K_PRE, 0, 0, 4'h0));
    repeat (5) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    q.push_back(mk(K_ACT, 100, 0, 4'hf));
    repeat (5) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    q.push_back(mk(K_RD, 41, 0, 4'hf));
    repeat (6) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    foreach (q[i]) begin
      cyc(q[i]);
      tests_run += 3;
      if (DRAM_valid !== m_valid) begin fails++; $display("FAIL b2b_post_valid e%0d got %b exp %b", edge_n, DRAM_valid, m_valid); end
      if (DRAM_Q !== m_q)         begin fails++; $display("FAIL b2b_post_q e%0d got %h exp %h", edge_n, DRAM_Q, m_q); end
      if (dram_err !== m_err)     begin fails++; $display("FAIL b2b_post_err e%0d got %b exp %b", edge_n, dram_err, m_err); end
    end
    tests_run += 2;
    if (dram_err !== 1'b0)        begin fails++; $display("FAIL b2b_err_final got %b exp 0", dram_err); end
    if (DRAM_Q !== 32'hC0DE_0001) begin fails++; $display("FAIL b2b_reopen got %h exp c0de0001", DRAM_Q); end
  endtask

  task automatic test_reset_inflight();
    cmd_t q[$];
    int nval = 0;
    do_reset();
    q.push_back(mk(K_ACT, 12, 0, 4'hf));
    repeat (5) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    q.push_back(mk(K_WR, 20, 32'h5EED_BEEF, 4'h0));
    q.push_back(mk(K_RD, 20, 0, 4'hf));
    repeat (5) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    q.push_back(mk(K_RD, 20, 0, 4'hf));
    repeat (2) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    foreach (q[i]) begin
      cyc(q[i]);
      tests_run += 2;
      if (DRAM_valid !== m_valid) begin fails++; $display("FAIL rip_valid e%0d got %b exp %b", edge_n, DRAM_valid, m_valid); end
      if (DRAM_Q !== m_q)         begin fails++; $display("FAIL rip_q e%0d got %h exp %h", edge_n, DRAM_Q, m_q); end
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    tests_run += 3;
    if (DRAM_Q !== 32'h0)    begin fails++; $display("FAIL async_q got %h exp 0", DRAM_Q); end
    if (DRAM_valid !== 1'b0) begin fails++; $display("FAIL async_valid got %b exp 0", DRAM_valid); end
    if (dram_err !== 1'b0)   begin fails++; $display("FAIL async_err got %b exp 0", dram_err); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    repeat (8) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    q.push_back(mk(K_ACT, 12, 0, 4'hf));
    repeat (5) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    q.push_back(mk(K_RD, 20, 0, 4'hf));
    repeat (6) q.push_back(mk(K_NOP, 0, 0, 4'hf));
    foreach (q[i]) begin
      cyc(q[i]);
      if (i < 8 && DRAM_valid === 1'b1) nval++;
      tests_run += 3;
      if (DRAM_valid !== m_valid) begin fails++; $display("FAIL rip2_valid e%0d got %b exp %b", edge_n, DRAM_valid, m_valid); end
      if (DRAM_Q !== m_q)         begin fails++; $display("FAIL rip2_q e%0d got %h exp %h", edge_n, DRAM_Q, m_q); end
      if (dram_err !== m_err)     begin fails++; $display("FAIL rip2_err e%0d got %b exp %b", edge_n, dram_err, m_err); end
    end
    tests_run += 2;
    if (nval != 0)                begin fails++; $display("FAIL rip_stale_valid got %0d exp 0", nval); end
    if (DRAM_Q !== 32'h5EED_BEEF) begin fails++; $display("FAIL rip_mem_kept got %h exp 5eedbeef", DRAM_Q); end
  endtask

  task automatic test_random();
    int    rows [2] = '{7, 2047};
    int    cols [4] = '{0, 1, 513, 1023};
    int    r, col, a;
    kind_t k;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      k = K_NOP; a = 0;
      col = cols[$urandom_range(0, 3)];
      if (m_rd_pend) k = K_NOP;
      else if (!m_open) begin
        if ((edge_n + 1 - m_pre_edge) >= TRP && $urandom_range(0, 1) == 1) begin
          k = K_ACT; a = rows[$urandom_range(0, 1)];
        end
      end else if ((edge_n + 1 - m_act_edge) >= TRCD) begin
        r = $urandom_range(0, 9);
        a = col + 1024 * $urandom_range(0, 1);
        if (r == 0) k = K_PRE;
        else if (r >= 3 && r <= 6) k = K_RD;
        else if (r >= 7) k = K_WR;
        if (k != K_PRE && k != K_NOP && !m_mem.exists(m_row * 1024 + col)) k = K_WR;
      end
      if (k == K_WR && !m_mem.exists(m_row * 1024 + col))
        cyc(mk(k, a, $urandom, 4'h0));
      else
        cyc(mk(k, a, $urandom, 4'($urandom_range(0, 14))));
      tests_run += 3;
      if (DRAM_valid !== m_valid) begin fails++; $display("FAIL rnd_valid e%0d got %b exp %b", edge_n, DRAM_valid, m_valid); end
      if (DRAM_Q !== m_q)         begin fails++; $display("FAIL rnd_q e%0d got %h exp %h", edge_n, DRAM_Q, m_q); end
      if (dram_err !== m_err)     begin fails++; $display("FAIL rnd_err e%0d got %b exp %b", edge_n, dram_err, m_err); end
    end
  endtask

  initial begin
    rst = 1'b0;
    DRAM_CSn = 1; DRAM_RASn = 1; DRAM_CASn = 1; DRAM_WEn = 4'hf; DRAM_A = '0; DRAM_D = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_byte_write();
    test_violations();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
